uart_word_rx: RTL and testbench

UART_WORD_RX -- requirements
Module: uart_word_rx

---
 rtl/uart_word_rx.sv | 144 ++++++++++++++
 tb/tb_uart_word_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_rx.sv
// uart_word_rx: packs a stream of UART bytes into DATA_WIDTH-bit words.
// The FSM collects bytes, holds a finished word until the consumer takes it,
// drops partial words on an inter-byte timeout or framing error, and reports
// lost bytes and framing errors through sticky flags.
module uart_word_rx #(
   parameter int DATA_WIDTH     = 32,
   parameter int LSB_FIRST      = 1,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic                  rx_err,
   output logic [DATA_WIDTH-1:0] word_o,
   output logic                  word_valid_o,
   input  logic                  word_ready_i,
   output logic                  busy_o,
   output logic                  timeout_o,
   output logic                  overrun_o,
   output logic                  frame_err_o,
   input  logic                  clr_err_i
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = $clog2(NB);
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
   // The gap counter starts at 0 on the edge that takes a byte, so the edge
   // where it would reach TIMEOUT_CYCLES-1 is the one that sees TIMEOUT_CYCLES-2.
   localparam logic [23:0] GAP_LAST = 24'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [23:0]   gap;

   logic acc, bad, ovr_set;

   // Byte qualification and sticky-flag set conditions.
   always_comb begin
      acc     = rx_valid & ~rx_err;
      bad     = rx_valid & rx_err;
      ovr_set = (state == FULL) & acc & ~word_ready_i;
   end

   // Write byte b into the lane selected by index k, keeping the other lanes.
   function automatic logic [DATA_WIDTH-1:0] place(input logic [DATA_WIDTH-1:0] base,
                                                  input logic [IW-1:0] k,
                                                  input logic [7:0] b);
      logic [DATA_WIDTH-1:0] w;
      int lane;
      w = base;
      lane = (LSB_FIRST != 0) ? int'(k) : NB - 1 - int'(k);
      w[lane*8 +: 8] = b;
      return w;
   endfunction

   // Main FSM with registered outputs; busy/valid track COLLECT/FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         gap          <= '0;
         word_o       <= '0;
         word_valid_o <= 1'b0;
         busy_o       <= 1'b0;
         timeout_o    <= 1'b0;
         overrun_o    <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         timeout_o   <= 1'b0;
         overrun_o   <= clr_err_i ? 1'b0 : (overrun_o | ovr_set);
         frame_err_o <= clr_err_i ? 1'b0 : (frame_err_o | bad);
         case (state)
            IDLE: begin
               if (acc) begin
                  word_o <= place('0, '0, rx_data);
                  idx    <= IW'(1);
                  gap    <= '0;
                  busy_o <= 1'b1;
                  state  <= COLLECT;
               end
            end
            COLLECT: begin
               if (bad) begin
                  word_o <= '0;
                  idx    <= '0;
                  gap    <= '0;
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end else if (gap == GAP_LAST) begin
                  // Timeout wins over a byte landing on the same edge; that
                  // byte becomes the first byte of a fresh word.
                  timeout_o <= 1'b1;
                  gap       <= '0;
                  if (acc) begin
                     word_o <= place('0, '0, rx_data);
                     idx    <= IW'(1);
                  end else begin
                     word_o <= '0;
                     idx    <= '0;
                     busy_o <= 1'b0;
                     state  <= IDLE;
                  end
               end else if (acc) begin
                  word_o <= place(word_o, idx, rx_data);
                  gap    <= '0;
                  if (idx == LAST_IDX) begin
                     idx          <= '0;
                     busy_o       <= 1'b0;
                     word_valid_o <= 1'b1;
                     state        <= FULL;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end else begin
                  gap <= gap + 24'd1;
               end
            end
            FULL: begin
               if (word_ready_i) begin
                  word_valid_o <= 1'b0;
                  if (acc) begin
                     word_o <= place('0, '0, rx_data);
                     idx    <= IW'(1);
                     gap    <= '0;
                     busy_o <= 1'b1;
                     state  <= COLLECT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state        <= IDLE;
               busy_o       <= 1'b0;
               word_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: two instances (LSB-first with a short timeout, and
// MSB-first with the default timeout) share one directed stimulus stream and
// are checked every cycle against a byte-list model, plus literal expectations.
module tb_uart_word_rx;

   logic        clk, rst_n, rx_valid, rx_err, word_ready_i, clr_err_i;
   logic [7:0]  rx_data;
   logic [31:0] wa, wb;
   logic        va, vb, ba, bb, ta, tb, oa, ob, fa, fb;

   uart_word_rx #(.DATA_WIDTH(32), .LSB_FIRST(1), .TIMEOUT_CYCLES(20)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
      .word_o(wa), .word_valid_o(va), .word_ready_i(word_ready_i), .busy_o(ba),
      .timeout_o(ta), .overrun_o(oa), .frame_err_o(fa), .clr_err_i(clr_err_i));

   uart_word_rx #(.DATA_WIDTH(32), .LSB_FIRST(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
      .word_o(wb), .word_valid_o(vb), .word_ready_i(word_ready_i), .busy_o(bb),
      .timeout_o(tb), .overrun_o(ob), .frame_err_o(fb), .clr_err_i(clr_err_i));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Per instance: list of bytes gathered so far, whether a finished word is
   // held, the cycle of the last accepted byte, and the flag values.
   int          m_n[2];
   logic [7:0]  m_b[2][4];
   bit          m_full[2];
   logic [31:0] m_w[2];
   longint      m_last[2];
   bit          m_to[2], m_ov[2], m_fe[2];
   longint      cyc = 0;
   int          TMO[2]  = '{20, 100000};
   bit          LSBF[2] = '{1'b1, 1'b0};

   task automatic m_start(input int i, input logic [7:0] d);
      m_b[i] = '{8'h0, 8'h0, 8'h0, 8'h0};
      m_b[i][0] = d;
      m_n[i] = 1;
      m_last[i] = cyc;
   endtask

   task automatic m_step(input int i);
      bit acc, bad, ovs;
      acc = rx_valid && !rx_err;
      bad = rx_valid && rx_err;
      ovs = 0;
      m_to[i] = 0;
      if (!rst_n) begin
         m_n[i] = 0; m_full[i] = 0; m_ov[i] = 0; m_fe[i] = 0;
         return;
      end
      if (m_full[i]) begin
         if (word_ready_i) begin
            m_full[i] = 0;
            if (acc) m_start(i, rx_data);
         end else if (acc) ovs = 1;
      end else if (m_n[i] > 0) begin
         if (bad) m_n[i] = 0;
         else if (cyc - m_last[i] == longint'(TMO[i] - 1)) begin
            m_to[i] = 1;
            if (acc) m_start(i, rx_data);
            else m_n[i] = 0;
         end else if (acc) begin
            m_b[i][m_n[i]] = rx_data;
            m_n[i]++;
            m_last[i] = cyc;
            if (m_n[i] == 4) begin
               m_full[i] = 1;
               m_n[i] = 0;
               m_w[i] = LSBF[i] ? {m_b[i][3], m_b[i][2], m_b[i][1], m_b[i][0]}
                                : {m_b[i][0], m_b[i][1], m_b[i][2], m_b[i][3]};
            end
         end
      end else if (acc) m_start(i, rx_data);
      m_fe[i] = clr_err_i ? 1'b0 : (m_fe[i] | bad);
      m_ov[i] = clr_err_i ? 1'b0 : (m_ov[i] | ovs);
   endtask

   task automatic cmp(input int i, input logic [31:0] w, input logic v, input logic b,
                      input logic t, input logic o, input logic f);
      string s;
      s = (i == 0) ? "a" : "b";
      chk({"valid_", s}, 32'(v), 32'(m_full[i]));
      chk({"busy_", s}, 32'(b), 32'(m_n[i] > 0));
      chk({"timeout_", s}, 32'(t), 32'(m_to[i]));
      chk({"overrun_", s}, 32'(o), 32'(m_ov[i]));
      chk({"frame_err_", s}, 32'(f), 32'(m_fe[i]));
      if (m_full[i]) chk({"word_", s}, w, m_w[i]);
   endtask

   // Step the model on each rising edge, compare 1 time unit later.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         m_step(0);
         m_step(1);
         #1;
         cmp(0, wa, va, ba, ta, oa, fa);
         cmp(1, wb, vb, bb, tb, ob, fb);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] d, input logic e = 1'b0);
      rx_valid = 1'b1; rx_data = d; rx_err = e;
      @(negedge clk);
      rx_valid = 1'b0; rx_err = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int seen, pulses;
      rst_n = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
      word_ready_i = 1'b1; clr_err_i = 1'b0;
      idle(3);
      chk("rst_word_a", wa, 32'h0);
      chk("rst_word_b", wb, 32'h0);
      chk("rst_flags_a", {va, ba, ta, oa, fa}, 32'h0);
      rst_n = 1'b1;

      // basic assembly, 10-cycle spacing
      for (int k = 0; k < 4; k++) begin
         send(8'(17 * (k + 1)));
         if (k < 3) idle(9);
      end
      chk("basic_word_a", wa, 32'h44332211);
      chk("basic_valid_a", 32'(va), 32'h1);
      chk("order_word_b", wb, 32'h11223344);
      idle(1);
      chk("basic_valid_drop_a", 32'(va), 32'h0);

      // overrun, clear priority, sticky through handshake
      word_ready_i = 1'b0;
      send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
      chk("full_valid_a", 32'(va), 32'h1);
      clr_err_i = 1'b1;
      send(8'h55);
      clr_err_i = 1'b0;
      chk("clr_priority_a", 32'(oa), 32'h0);
      send(8'h56);
      chk("overrun_a", 32'(oa), 32'h1);
      chk("overrun_word_a", wa, 32'hA4A3A2A1);
      word_ready_i = 1'b1;
      idle(1);
      word_ready_i = 1'b0;
      chk("handshake_valid_a", 32'(va), 32'h0);
      chk("overrun_sticky_a", 32'(oa), 32'h1);
      clr_err_i = 1'b1;
      idle(1);
      clr_err_i = 1'b0;
      chk("overrun_clr_a", 32'(oa), 32'h0);

      // back-to-back: byte on the handshake cycle
      send(8'hB1); send(8'hB2); send(8'hB3); send(8'hB4);
      idle(2);
      word_ready_i = 1'b1;
      send(8'hC1);
      chk("b2b_overrun_a", 32'(oa), 32'h0);
      chk("b2b_busy_a", 32'(ba), 32'h1);
      send(8'hC2); send(8'hC3); send(8'hC4);
      chk("b2b_word_a", wa, 32'hC4C3C2C1);

      // timeout
      send(8'hAA); send(8'hBB);
      seen = -1; pulses = 0;
      for (int n = 1; n <= 25; n++) begin
         @(negedge clk);
         if (ta) begin
            pulses++;
            if (seen < 0) seen = n;
         end
      end
      chk("timeout_delay_a", 32'(seen), 32'd19);
      chk("timeout_pulses_a", 32'(pulses), 32'd1);
      chk("timeout_busy_a", 32'(ba), 32'h0);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      chk("after_timeout_word_a", wa, 32'h04030201);

      // byte on the timeout edge starts a new word
      send(8'h5A);
      idle(18);
      send(8'h5B);
      chk("tmo_edge_pulse_a", 32'(ta), 32'h1);
      chk("tmo_edge_busy_a", 32'(ba), 32'h1);
      send(8'h5C); send(8'h5D); send(8'h5E);
      chk("tmo_edge_word_a", wa, 32'h5E5D5C5B);

      // framing error on the second byte
      send(8'h11);
      send(8'h22, 1'b1);
      chk("ferr_a", 32'(fa), 32'h1);
      chk("ferr_busy_a", 32'(ba), 32'h0);
      clr_err_i = 1'b1;
      idle(1);
      clr_err_i = 1'b0;
      chk("ferr_clr_a", 32'(fa), 32'h0);

      // reset mid-word
      send(8'h01); send(8'h02);
      chk("pre_rst_busy_a", 32'(ba), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_a", {wa[7:0], va, ba, ta, oa, fa}, 32'h0);
      chk("mid_rst_word_b", wb, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(25);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h21);
      chk("first_edge_busy_a", 32'(ba), 32'h1);
      send(8'h22); send(8'h23); send(8'h24);
      chk("post_rst_word_a", wa, 32'h24232221);
      chk("post_rst_word_b", wb, 32'h21222324);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
